instr_fetch: RTL and testbench

Instruction supply unit feeding the CPU's 8-bit `instruction` input. Holds a loadable program memory and a program counter. Presents one instruction at a time with a valid flag and advances on the CPU's `LoadIR` strobe. Also accepts jump redirects from the controller's immediate-data path and stops on a halt opcode. Sits between the program loader (testbench or boot logic) and the CPU top.

---
 rtl/instr_fetch_if.sv | 33 +++
 rtl/instr_fetch.sv | 115 +++++++++++
 tb/tb_instr_fetch.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Bus between the fetch unit (slave) and its users: the program loader and the CPU (master).
//
// Handshake: the fetch unit raises instr_valid when instruction/pc hold a fetched word.
// The CPU pulses LoadIR for one cycle while instr_valid=1 to consume that word and advance.
// Jump redirects fetch to JumpAddr and takes priority over LoadIR. LoadIR and Jump have no
// effect unless the fetch unit is presenting a word (READY). fsm_state is a debug view of the
// fetch unit's FSM.
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [7:0]        prog_data;
    logic              start;
    logic              LoadIR;
    logic              Jump;
    logic [ADDR_W-1:0] JumpAddr;
    logic [7:0]        instruction;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic [1:0]        fsm_state;

    modport master (
        output prog_we, prog_addr, prog_data, start, LoadIR, Jump, JumpAddr,
        input  instruction, instr_valid, pc, halted, fsm_state
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, start, LoadIR, Jump, JumpAddr,
        output instruction, instr_valid, pc, halted, fsm_state
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction supply unit: loadable program memory plus program counter, presenting one
// instruction at a time to the CPU. Advances on LoadIR, redirects on Jump, stops on HALT_OPCODE.
// Optional feature macro: INSTR_FETCH_PREFETCH_EN -- the word at pc+1 is read during every
// READY cycle and captured on LoadIR, so consecutive words are presented with no bubble.
module instr_fetch #(
    parameter int          ADDR_W      = 8,
    parameter int          DEPTH       = 256,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
    input  logic         clk,
    input  logic         reset,
    instr_fetch_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_q, pc_next, pc_inc;
    logic [7:0]        instr_q, instr_next;
    logic              valid_q, valid_next;
    logic              halted_q, halted_next;
    logic              mem_we;
    logic [7:0]        mem [DEPTH];

    // Natural ADDR_W overflow gives the DEPTH-1 -> 0 wrap since DEPTH == 2**ADDR_W.
    assign pc_inc = pc_q + 1'b1;

    // The loader owns memory only while fetching is stopped.
    assign mem_we = bus.prog_we && ((state == IDLE) || (state == HALT));

    // Program memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    // State and presented-word registers; reset aborts any in-flight fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            pc_q     <= '0;
            instr_q  <= 8'h00;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_next;
            pc_q     <= pc_next;
            instr_q  <= instr_next;
            valid_q  <= valid_next;
            halted_q <= halted_next;
        end
    end

    // Next-state and datapath decisions; everything holds unless a branch says otherwise.
    always_comb begin
        state_next  = state;
        pc_next     = pc_q;
        instr_next  = instr_q;
        valid_next  = valid_q;
        halted_next = halted_q;
        case (state)
            IDLE, HALT: begin
                if (bus.start) begin
                    pc_next     = '0;
                    valid_next  = 1'b0;
                    halted_next = 1'b0;
                    state_next  = FETCH;
                end
            end
            FETCH: begin
                instr_next = mem[pc_q];
                valid_next = 1'b1;
                if (mem[pc_q] == HALT_OPCODE) begin
                    halted_next = 1'b1;
                    state_next  = HALT;
                end else begin
                    state_next  = READY;
                end
            end
            READY: begin
                if (bus.Jump) begin
                    // Any word already read ahead belongs to the old stream and is dropped.
                    pc_next    = bus.JumpAddr;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (bus.LoadIR) begin
                    pc_next = pc_inc;
`ifdef INSTR_FETCH_PREFETCH_EN
                    // Word at pc+1 is already being read this cycle; present it directly.
                    instr_next = mem[pc_inc];
                    if (mem[pc_inc] == HALT_OPCODE) begin
                        halted_next = 1'b1;
                        state_next  = HALT;
                    end
`else
                    valid_next = 1'b0;
                    state_next = FETCH;
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.instruction = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.halted      = halted_q;
    assign bus.fsm_state   = state;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a vector table for the basic fetch/halt sequence, hand-written
// sequences for jump priority, wrap, loader gating, continuous LoadIR and async reset, and a
// scoreboard that checks every newly presented {pc, instruction} against a memory model.
module tb_instr_fetch;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    instr_fetch_if #(.ADDR_W(8)) bus ();

    instr_fetch #(.ADDR_W(8), .DEPTH(256), .HALT_OPCODE(8'hFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    logic [7:0]  model [256];
    logic [15:0] exp_q [$];

    typedef struct packed {
        logic       start;
        logic       ld;
        logic       jmp;
        logic [7:0] jaddr;
        logic       push;
        logic [7:0] push_addr;
        logic       e_valid;
        logic [7:0] e_pc;
        logic [7:0] e_instr;
        logic       e_halted;
    } vec_t;

    vec_t vecs [10];
    int   n_vecs;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic l, input logic j, input logic [7:0] ja);
        bus.start    = s;
        bus.LoadIR   = l;
        bus.Jump     = j;
        bus.JumpAddr = ja;
    endtask

    task automatic push(input logic [7:0] a);
        exp_q.push_back({a, model[a]});
    endtask

    task automatic prog(input logic [7:0] a, input logic [7:0] d, input bit upd);
        bus.prog_we   = 1'b1;
        bus.prog_addr = a;
        bus.prog_data = d;
        if (upd) model[a] = d;
        step();
        bus.prog_we = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [7:0] p,
                              input logic [7:0] ins, input logic h);
        check({tag, "_valid"}, {31'd0, bus.instr_valid}, {31'd0, v});
        check({tag, "_pc"}, {24'd0, bus.pc}, {24'd0, p});
        check({tag, "_halted"}, {31'd0, bus.halted}, {31'd0, h});
        if (v) check({tag, "_instr"}, {24'd0, bus.instruction}, {24'd0, ins});
    endtask

    // Scoreboard monitor: a new word is presented when valid rises or pc moves while valid.
    logic       mon_prev_valid;
    logic [7:0] mon_prev_pc;
    always @(negedge clk) begin
        if (reset) begin
            mon_prev_valid = 1'b0;
            mon_prev_pc    = 8'h00;
        end else begin
            if (bus.instr_valid && (!mon_prev_valid || bus.pc != mon_prev_pc)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected got %h want none", {bus.pc, bus.instruction});
                end else begin
                    check("sb_word", {16'd0, bus.pc, bus.instruction}, {16'd0, exp_q.pop_front()});
                end
            end
            mon_prev_valid = bus.instr_valid;
            mon_prev_pc    = bus.pc;
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.prog_we   = 1'b0;
        bus.prog_addr = 8'h00;
        bus.prog_data = 8'h00;
        drive(0, 0, 0, 8'h00);
        for (int i = 0; i < 256; i++) model[i] = 8'h00;

        // Vector table: inputs for one cycle, outputs expected after the following edge.
`ifdef INSTR_FETCH_PREFETCH_EN
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h11, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h11, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 8'h01, 8'h22, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h02, 8'hFF, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 8'hFF, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 8'h02, 8'hFF, 1'b1};
        n_vecs = 7;
`else
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h11, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h00, 8'h11, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h01, 8'h00, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h01, 8'h22, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h02, 8'h00, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 8'hFF, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 8'h02, 8'hFF, 1'b1};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 8'h02, 8'hFF, 1'b1};
        n_vecs = 9;
`endif

        // Reset state.
        step();
        step();
        reset = 1'b0;
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_pc", {24'd0, bus.pc}, 32'd0);
        check("rst_instr", {24'd0, bus.instruction}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_state", {30'd0, bus.fsm_state}, 32'd0);

        // Program load in IDLE.
        prog(8'h00, 8'h11, 1);
        prog(8'h01, 8'h22, 1);
        prog(8'h02, 8'hFF, 1);
        prog(8'h05, 8'h55, 1);
        prog(8'h40, 8'h5A, 1);
        prog(8'hFF, 8'h07, 1);
        for (int i = 0; i < 8; i++) prog(8'h10 + 8'(i), 8'hA0 + 8'(i), 1);

        // Table: start, advance, halt, LoadIR/Jump ignored in HALT.
        for (int i = 0; i < n_vecs; i++) begin
            drive(vecs[i].start, vecs[i].ld, vecs[i].jmp, vecs[i].jaddr);
            if (vecs[i].push) push(vecs[i].push_addr);
            step();
            drive(0, 0, 0, 8'h00);
            expect_out($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc,
                       vecs[i].e_instr, vecs[i].e_halted);
        end
        check("halt_state", {30'd0, bus.fsm_state}, 32'd3);

        // Loader write in HALT together with start: refetch sees the new word.
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'h00;
        bus.prog_data = 8'h33;
        model[0]      = 8'h33;
        drive(1, 0, 0, 8'h00);
        push(8'h00);
        step();
        bus.prog_we = 1'b0;
        drive(0, 0, 0, 8'h00);
        expect_out("restart_a", 1'b0, 8'h00, 8'h00, 1'b0);
        step();
        expect_out("restart_b", 1'b1, 8'h00, 8'h33, 1'b0);

        // Jump wins over LoadIR in the same cycle.
        drive(0, 1, 1, 8'h40);
        push(8'h40);
        step();
        drive(0, 0, 0, 8'h00);
        expect_out("jprio_a", 1'b0, 8'h40, 8'h00, 1'b0);
        step();
        expect_out("jprio_b", 1'b1, 8'h40, 8'h5A, 1'b0);

        // Loader write while READY is ignored.
        prog(8'h05, 8'hEE, 0);
        drive(0, 0, 1, 8'h05);
        push(8'h05);
        step();
        drive(0, 0, 0, 8'h00);
        step();
        expect_out("we_ignored", 1'b1, 8'h05, 8'h55, 1'b0);

        // Wrap from DEPTH-1 to 0.
        drive(0, 0, 1, 8'hFF);
        push(8'hFF);
        step();
        drive(0, 0, 0, 8'h00);
        step();
        expect_out("wrap_a", 1'b1, 8'hFF, 8'h07, 1'b0);
        drive(0, 1, 0, 8'h00);
        push(8'h00);
        step();
        drive(0, 0, 0, 8'h00);
`ifndef INSTR_FETCH_PREFETCH_EN
        expect_out("wrap_bubble", 1'b0, 8'h00, 8'h00, 1'b0);
        step();
`endif
        expect_out("wrap_b", 1'b1, 8'h00, 8'h33, 1'b0);

        // Continuous LoadIR from 0x10.
        drive(0, 0, 1, 8'h10);
        push(8'h10);
        step();
        drive(0, 0, 0, 8'h00);
        step();
        expect_out("burst_start", 1'b1, 8'h10, 8'hA0, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            drive(0, 1, 0, 8'h00);
`ifdef INSTR_FETCH_PREFETCH_EN
            push(8'h10 + 8'(i));
            step();
            expect_out($sformatf("burst%0d", i), 1'b1, 8'h10 + 8'(i), 8'hA0 + 8'(i), 1'b0);
`else
            if (i % 2 == 1) push(8'h10 + 8'((i + 1) / 2));
            step();
            expect_out($sformatf("burst%0d", i), (i % 2 == 0), 8'h10 + 8'((i + 1) / 2),
                       8'hA0 + 8'((i + 1) / 2), 1'b0);
`endif
        end
        drive(0, 0, 0, 8'h00);

        // Asynchronous reset in the middle of a fetch.
        drive(0, 0, 1, 8'h02);
        step();
        drive(0, 0, 0, 8'h00);
        check("pre_rst_state", {30'd0, bus.fsm_state}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("arst_pc", {24'd0, bus.pc}, 32'd0);
        check("arst_instr", {24'd0, bus.instruction}, 32'd0);
        check("arst_halted", {31'd0, bus.halted}, 32'd0);
        check("arst_state", {30'd0, bus.fsm_state}, 32'd0);
        step();
        reset = 1'b0;
        drive(1, 0, 0, 8'h00);
        push(8'h00);
        step();
        drive(0, 0, 0, 8'h00);
        step();
        expect_out("post_rst", 1'b1, 8'h00, 8'h33, 1'b0);

        step();
        check("sb_drain", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
